// File: rtl/hex_display_pkg.sv
// Shared definitions for the eight-digit hex display driver.
// Contents: segment type, the sixteen active-low hex glyphs ({g,f,e,d,c,b,a}),
// the blank segment pattern and the all-digits-off anode pattern.
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t GLYPH_0 = 7'h40;
    localparam seg_t GLYPH_1 = 7'h79;
    localparam seg_t GLYPH_2 = 7'h24;
    localparam seg_t GLYPH_3 = 7'h30;
    localparam seg_t GLYPH_4 = 7'h19;
    localparam seg_t GLYPH_5 = 7'h12;
    localparam seg_t GLYPH_6 = 7'h02;
    localparam seg_t GLYPH_7 = 7'h78;
    localparam seg_t GLYPH_8 = 7'h00;
    localparam seg_t GLYPH_9 = 7'h10;
    localparam seg_t GLYPH_A = 7'h08;
    localparam seg_t GLYPH_B = 7'h03;
    localparam seg_t GLYPH_C = 7'h46;
    localparam seg_t GLYPH_D = 7'h21;
    localparam seg_t GLYPH_E = 7'h06;
    localparam seg_t GLYPH_F = 7'h0E;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble-to-glyph decoder for a common-anode seven-segment digit.
// Ports:
//   nibble - 4-bit hex value
//   seg    - active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/hex_display_driver.sv
// Multiplexed eight-digit hex display driver (common anode, active-low).
// A snapshot of data_i is taken only at the end of the last digit slot of a
// frame, so one frame never mixes two words; hold_i suppresses that capture.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - synchronous active-high reset
//   data_i - 32-bit word to display
//   hold_i - 1 keeps the current snapshot
//   an_o   - digit enables, active-low, bit i = digit i (digit 0 = LS nibble)
//   seg_o  - segments, active-low {g,f,e,d,c,b,a}
//   dp_o   - decimal point, active-low; lit on digit 0 while holding
// Build option: define HEX_LEADING_ZERO_BLANK_EN to blank digits above the
// most significant non-zero nibble (digit 0 is always shown).
module hex_display_driver
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        hold_i,
    output logic [7:0]  an_o,
    output seg_t        seg_o,
    output logic        dp_o
);

    localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    logic [CntW-1:0] pcnt_q, pcnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     snap_q, snap_d;
    logic [7:0]      an_q, an_d;
    seg_t            seg_q, seg_d;
    logic            dp_q, dp_d;

    logic tc;
    logic blank;
    seg_t glyph;

    assign tc = (pcnt_q == CntW'(DIGIT_CYCLES - 1));

    always_comb begin
        pcnt_d = tc ? '0 : pcnt_q + CntW'(1);
        idx_d  = tc ? idx_q + 3'd1 : idx_q;
        snap_d = snap_q;
        // Capture only at the frame boundary so the next frame is consistent.
        if (tc && (idx_q == 3'd7) && !hold_i) begin
            snap_d = data_i;
        end
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (snap_q[{idx_q, 2'b00} +: 4]),
        .seg    (glyph)
    );

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic [2:0] msn;

    // Index of the most significant non-zero nibble; 0 when snap is zero.
    always_comb begin
        msn = '0;
        for (int i = 1; i < 8; i++) begin
            if (snap_q[4*i +: 4] != 4'h0) begin
                msn = 3'(i);
            end
        end
    end

    assign blank = (idx_q > msn);
`else
    assign blank = 1'b0;
`endif

    // Enable and segments are registered together so they switch on the same edge.
    always_comb begin
        an_d  = blank ? AN_OFF : ~(8'h01 << idx_q);
        seg_d = blank ? SEG_BLANK : glyph;
        dp_d  = !((idx_q == 3'd0) && hold_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_q <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= AN_OFF;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule

// File: tb/tb_hex_display_driver.sv
module tb_hex_display_driver;

    localparam int DC    = 4;
    localparam int FRAME = 8 * DC;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = '0;
    logic        hold = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks = 0;
    int fails  = 0;

    // Reference model: edges since reset release and the word shown this frame.
    int          e = 0;
    logic [31:0] m_snap = '0;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    hex_display_driver #(.DIGIT_CYCLES(DC)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (data),
        .hold_i (hold),
        .an_o   (an),
        .seg_o  (seg),
        .dp_o   (dp)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic h, input logic [31:0] d);
        int   slot;
        int   top;
        logic [3:0] nib;
        rst  = r;
        hold = h;
        data = d;
        @(posedge clk);
        if (r) begin
            e       = 0;
            m_snap  = '0;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            e++;
            slot    = ((e - 1) / DC) % 8;
            nib     = 4'((m_snap >> (4 * slot)) & 32'hF);
            exp_an  = ~(8'h01 << slot);
            exp_seg = GLYPH[nib];
            exp_dp  = !((slot == 0) && h);
`ifdef HEX_LEADING_ZERO_BLANK_EN
            top = 0;
            for (int i = 0; i < 8; i++) begin
                if (((m_snap >> (4 * i)) & 32'hF) != 0) top = i;
            end
            if (slot > top) begin
                exp_an  = 8'hFF;
                exp_seg = 7'h7F;
            end
`else
            top = 7;
`endif
            if ((e % FRAME == 0) && !h) m_snap = d;
        end
        #1;
        checks++;
        assert (an === exp_an) else begin
            fails++;
            $error("FAIL an e=%0d got %h want %h", e, an, exp_an);
        end
        checks++;
        assert (seg === exp_seg) else begin
            fails++;
            $error("FAIL seg e=%0d got %h want %h", e, seg, exp_seg);
        end
        checks++;
        assert (dp === exp_dp) else begin
            fails++;
            $error("FAIL dp e=%0d got %b want %b", e, dp, exp_dp);
        end
    endtask

    initial begin
        logic h;
        logic [31:0] d;

        // Reset held for three cycles.
        repeat (3) step(1'b1, 1'b0, 32'h0);

        // Frame 1 shows zeros while 1234ABCF is presented for capture.
        repeat (FRAME) step(1'b0, 1'b0, 32'h1234_ABCF);

        // Frame 2: first slot must be 'F'.
        step(1'b0, 1'b0, 32'h1234_ABCF);
        checks++;
        assert (seg === 7'h0E && an === 8'hFE) else begin
            fails++;
            $error("FAIL frame2_digit0 got an=%h seg=%h want an=fe seg=0e", an, seg);
        end
        repeat (15) step(1'b0, 1'b0, 32'h1234_ABCF);
        // Mid-frame data change must not disturb frame 2.
        repeat (11) step(1'b0, 1'b0, $urandom);
        // Hold before the end of frame 2, then clear the data.
        while (e < 3 * FRAME) step(1'b0, 1'b1, 32'h0);
        // Release hold: zeros captured at the next boundary.
        repeat (2 * FRAME) step(1'b0, 1'b0, 32'h0);

        // Small values to exercise leading-digit handling, then reset in slot 5.
        repeat (FRAME) step(1'b0, 1'b0, 32'h0000_0012);
        repeat (FRAME) step(1'b0, 1'b0, 32'h0000_0000);
        for (int k = 0; k < FRAME && (e % FRAME) != 22; k++) step(1'b0, 1'b0, 32'h0000_0012);
        step(1'b1, 1'b0, 32'h0000_0012);
        repeat (FRAME + 8) step(1'b0, 1'b0, $urandom);

        // Randomized phase with occasional reset and hold toggles.
        h = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 29) == 0) h = ~h;
            d = $urandom >> $urandom_range(0, 31);
            step(($urandom_range(0, 249) == 0), h, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
